// File: rtl/matrix_mul_pkg.sv
// Shared definitions for the matrix multiplier datapath: state encoding, default sizes
// and width helpers used by the multiplier, the result collector and the writer.
package matrix_mul_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 32;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } collect_state_e;

  // Row/column index width; never narrower than one bit so N=1 still builds.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element counter width: must hold the value N*N itself.
  function automatic int cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic logic idx_in_range(input int idx, input int n);
    return idx < n;
  endfunction

endpackage

// File: rtl/matrix_result_collector_result_store.sv
// N x N element buffer for the result collector: one synchronous write port and one
// combinational read port, both addressed by (row, column). Contents are never reset.
module result_store
  import matrix_mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_i,
  input  logic [IDX_W-1:0] wr_j,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_i][wr_j] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_i][rd_j];

endmodule

// File: rtl/matrix_result_collector.sv
// Collects multiplier results in any order into an N x N buffer, then streams the full
// matrix out. Define COLLECTOR_TRANSPOSE_EN to drain the transpose instead.
module matrix_result_collector
  import matrix_mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [W-1:0]     z_in,
  input  logic [IDX_W-1:0] z_i,
  input  logic [IDX_W-1:0] z_j,
  input  logic             z_stb,
  output logic             z_ack,
  output logic [W-1:0]     out_value,
  output logic [IDX_W-1:0] out_i,
  output logic [IDX_W-1:0] out_j,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             full,
  output logic             dup_err,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N * N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  collect_state_e          state_q;
  logic [N-1:0][N-1:0]     valid_q;
  logic [CW-1:0]           count_q;
  logic                    z_ack_q;
  logic                    out_stb_q;
  logic                    full_q;
  logic                    dup_err_q;
  logic                    done_q;
  logic [W-1:0]            out_value_q;
  logic [IDX_W-1:0]        out_i_q;
  logic [IDX_W-1:0]        out_j_q;

  logic                    accept;
  logic                    in_range;
  logic                    is_dup;
  logic                    last_accept;
  logic                    last_elem;
  logic [IDX_W-1:0]        nxt_i;
  logic [IDX_W-1:0]        nxt_j;
  logic [IDX_W-1:0]        rd_row;
  logic [IDX_W-1:0]        rd_col;
  logic [IDX_W-1:0]        rd_i;
  logic [IDX_W-1:0]        rd_j;
  logic [W-1:0]            rd_data;
  logic [W-1:0]            first_data;

  // Handshakes: an element is taken on a clk edge where z_stb=1 and z_ack=0; z_ack then
  // pulses high for one cycle. Downstream, out_* is valid while out_stb=1 and is consumed
  // on an edge where out_ack=1; the next element appears on the following cycle.
  assign accept   = (state_q == ST_COLLECT) && z_stb && !z_ack_q && !clear;
  assign in_range = idx_in_range(int'(z_i), N) && idx_in_range(int'(z_j), N);
  assign is_dup   = in_range && valid_q[z_i][z_j];
  assign last_accept = accept && in_range && !is_dup && (count_q == CNT_LAST);
  assign last_elem   = (out_i_q == IDX_LAST) && (out_j_q == IDX_LAST);

  always_comb begin
    nxt_i = out_i_q;
    nxt_j = out_j_q + IDX_W'(1);
    if (out_j_q == IDX_LAST) begin
      nxt_i = out_i_q + IDX_W'(1);
      nxt_j = '0;
    end
  end

  // While collecting, the read port is parked on (0,0) so the first drain element is
  // ready the instant the matrix completes; during DRAIN it looks one element ahead.
  assign rd_row = (state_q == ST_DRAIN) ? nxt_i : '0;
  assign rd_col = (state_q == ST_DRAIN) ? nxt_j : '0;

`ifdef COLLECTOR_TRANSPOSE_EN
  assign rd_i = rd_col;
  assign rd_j = rd_row;
`else
  assign rd_i = rd_row;
  assign rd_j = rd_col;
`endif

  // The final element may itself be (0,0); its write lands on the same edge as the load.
  assign first_data = (z_i == '0 && z_j == '0) ? z_in : rd_data;

  result_store #(
    .N     (N),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .we      (accept && in_range),
    .wr_i    (z_i),
    .wr_j    (z_j),
    .wr_data (z_in),
    .rd_i    (rd_i),
    .rd_j    (rd_j),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_COLLECT;
      valid_q     <= '0;
      count_q     <= '0;
      z_ack_q     <= 1'b0;
      out_stb_q   <= 1'b0;
      full_q      <= 1'b0;
      dup_err_q   <= 1'b0;
      done_q      <= 1'b0;
      out_value_q <= '0;
      out_i_q     <= '0;
      out_j_q     <= '0;
    end else if (clear) begin
      state_q   <= ST_COLLECT;
      valid_q   <= '0;
      count_q   <= '0;
      z_ack_q   <= 1'b0;
      out_stb_q <= 1'b0;
      full_q    <= 1'b0;
      dup_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          z_ack_q <= accept;
          if (accept) begin
            if (!in_range || is_dup) begin
              dup_err_q <= 1'b1;
            end else begin
              valid_q[z_i][z_j] <= 1'b1;
              count_q           <= count_q + CW'(1);
            end
            // The ack for this last element still pulses on the first DRAIN cycle.
            if (last_accept) begin
              state_q     <= ST_DRAIN;
              full_q      <= 1'b1;
              out_stb_q   <= 1'b1;
              out_value_q <= first_data;
              out_i_q     <= '0;
              out_j_q     <= '0;
            end
          end
        end
        ST_DRAIN: begin
          z_ack_q <= 1'b0;
          if (out_ack) begin
            if (last_elem) begin
              state_q   <= ST_DONE;
              out_stb_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              out_value_q <= rd_data;
              out_i_q     <= nxt_i;
              out_j_q     <= nxt_j;
            end
          end
        end
        ST_DONE: begin
          z_ack_q <= 1'b0;
        end
        default: begin
          state_q <= ST_COLLECT;
          z_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign z_ack     = z_ack_q;
  assign out_value = out_value_q;
  assign out_i     = out_i_q;
  assign out_j     = out_j_q;
  assign out_stb   = out_stb_q;
  assign full      = full_q;
  assign dup_err   = dup_err_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector: fill orders, duplicates, backpressure,
// clear and asynchronous reset, with a reference matrix and expected-drain queue.
module tb_matrix_result_collector;
  import matrix_mul_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  z_in = '0;
  logic [IW-1:0] z_i = '0;
  logic [IW-1:0] z_j = '0;
  logic          z_stb = 1'b0;
  logic          z_ack;
  logic [W-1:0]  out_value;
  logic [IW-1:0] out_i;
  logic [IW-1:0] out_j;
  logic          out_stb;
  logic          out_ack = 1'b0;
  logic          full;
  logic          dup_err;
  logic          done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  mdl [N][N];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_v[$];
  logic [IW-1:0] got_i[$];
  logic [IW-1:0] got_j[$];

  matrix_result_collector #(.N(N), .W(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .z_in      (z_in),
    .z_i       (z_i),
    .z_j       (z_j),
    .z_stb     (z_stb),
    .z_ack     (z_ack),
    .out_value (out_value),
    .out_i     (out_i),
    .out_j     (out_j),
    .out_stb   (out_stb),
    .out_ack   (out_ack),
    .full      (full),
    .dup_err   (dup_err),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic send_elem(input logic [IW-1:0] i, input logic [IW-1:0] j,
                           input logic [W-1:0] v, output int wait_cyc, output bit one_cycle);
    @(negedge clk);
    z_i = i; z_j = j; z_in = v; z_stb = 1'b1;
    wait_cyc = -1;
    one_cycle = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (z_ack) begin
        wait_cyc = c;
        break;
      end
    end
    z_stb = 1'b0;
    @(negedge clk);
    one_cycle = (wait_cyc >= 0) && !z_ack;
    if (wait_cyc >= 0) mdl[i][j] = v;
  endtask

  // order 0: forward (0,0)..(3,3); order 1: reverse. Value of k-th send is base+k.
  task automatic fill_seq(input int order, input int base, output int bad_acks,
                          output int full_early);
    int w;
    bit one;
    int p;
    bad_acks = 0;
    full_early = 0;
    for (int k = 0; k < N * N; k++) begin
      p = (order == 0) ? k : (N * N - 1 - k);
      send_elem(IW'(p / N), IW'(p % N), W'(base + k), w, one);
      if (w < 0 || !one) bad_acks++;
      if (k < N * N - 1 && full) full_early++;
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < N * N; k++) begin
`ifdef COLLECTOR_TRANSPOSE_EN
      exp_q.push_back(mdl[k % N][k / N]);
`else
      exp_q.push_back(mdl[k / N][k % N]);
`endif
    end
  endtask

  // out_ack is high on one of every `period` cycles; stops at done or after max_x transfers.
  task automatic drain_stream(input int period, input int max_x, output int n_x,
                              output int unstable, output bit timed_out);
    logic          held;
    logic [W-1:0]  hv;
    logic [IW-1:0] hi;
    logic [IW-1:0] hj;
    got_v.delete(); got_i.delete(); got_j.delete();
    n_x = 0; unstable = 0; timed_out = 1'b1;
    held = 1'b0; hv = '0; hi = '0; hj = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done || n_x >= max_x) begin
        timed_out = 1'b0;
        break;
      end
      out_ack = ((cyc % period) == period - 1);
      if (out_stb) begin
        if (held && (out_value !== hv || out_i !== hi || out_j !== hj)) unstable++;
        if (out_ack) begin
          got_v.push_back(out_value); got_i.push_back(out_i); got_j.push_back(out_j);
          n_x++;
          held = 1'b0;
        end else begin
          held = 1'b1; hv = out_value; hi = out_i; hj = out_j;
        end
      end
    end
    out_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({z_ack, out_stb, full, dup_err, done} !== 5'b0 || out_value !== '0 ||
        out_i !== '0 || out_j !== '0 || dbg_state !== 2'(ST_COLLECT)) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b stb=%b full=%b dup=%b done=%b val=%0h st=%0d, need all 0",
               z_ack, out_stb, full, dup_err, done, out_value, dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_order_fill();
    int bad, early, n, uns;
    bit to;
    fill_seq(0, 0, bad, early);
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL inorder_acks: bad=%0d need 0", bad); end
    checks++;
    if (early !== 0 || full !== 1'b1 || dup_err !== 1'b0) begin
      failures++;
      $display("FAIL inorder_full: early=%0d full=%b dup=%b need 0/1/0", early, full, dup_err);
    end
    build_exp();
    drain_stream(1, N * N, n, uns, to);
    checks++;
    if (to || n !== N * N) begin failures++; $display("FAIL inorder_count: got %0d to=%b need 16", n, to); end
    for (int k = 0; k < got_v.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_v[k] !== exp_q[k] || got_i[k] !== IW'(k / N) || got_j[k] !== IW'(k % N)) begin
        failures++;
        $display("FAIL inorder_elem%0d: got %0d@(%0d,%0d) need %0d@(%0d,%0d)", k,
                 got_v[k], got_i[k], got_j[k], exp_q[k], k / N, k % N);
      end
    end
    checks++;
    if (done !== 1'b1 || out_stb !== 1'b0 || full !== 1'b1 || dbg_state !== 2'(ST_DONE)) begin
      failures++;
      $display("FAIL inorder_done: done=%b stb=%b full=%b st=%0d need 1/0/1/2", done, out_stb, full, dbg_state);
    end
    pulse_clear();
  endtask

  task automatic test_reverse_fill();
    int bad, early, n, uns, acks;
    bit to;
    fill_seq(1, 100, bad, early);
    checks++;
    if (bad !== 0 || early !== 0) begin
      failures++; $display("FAIL reverse_acks: bad=%0d early=%0d need 0/0", bad, early);
    end
    build_exp();
    checks++;
    if (out_stb !== 1'b1 || out_value !== 32'd115) begin
      failures++; $display("FAIL reverse_first: stb=%b val=%0d need 1/115", out_stb, out_value);
    end
    drain_stream(1, N * N, n, uns, to);
    checks++;
    if (to || n !== N * N) begin failures++; $display("FAIL reverse_count: got %0d need 16", n); end
    for (int k = 0; k < got_v.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_v[k] !== exp_q[k] || got_i[k] !== IW'(k / N) || got_j[k] !== IW'(k % N)) begin
        failures++;
        $display("FAIL reverse_elem%0d: got %0d@(%0d,%0d) need %0d", k, got_v[k], got_i[k], got_j[k], exp_q[k]);
      end
    end
    @(negedge clk);
    z_i = '0; z_j = '0; z_in = 32'hdead; z_stb = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (z_ack) acks++;
    end
    z_stb = 1'b0;
    checks++;
    if (acks !== 0 || done !== 1'b1 || full !== 1'b1) begin
      failures++; $display("FAIL done_ignores_stb: acks=%0d done=%b full=%b need 0/1/1", acks, done, full);
    end
    pulse_clear();
  endtask

  task automatic test_duplicate();
    int w, bad, n, uns, p;
    bit one, to;
    bad = 0;
    send_elem(2'd1, 2'd2, 32'd7, w, one);
    if (w < 0 || !one) bad++;
    checks++;
    if (dup_err !== 1'b0) begin failures++; $display("FAIL dup_first: dup=%b need 0", dup_err); end
    send_elem(2'd1, 2'd2, 32'd9, w, one);
    if (w < 0 || !one) bad++;
    checks++;
    if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_second: dup=%b need 1", dup_err); end
    for (int k = 0; k < N * N; k++) begin
      if (k == 6) continue;
      send_elem(IW'(k / N), IW'(k % N), W'(300 + k), w, one);
      if (w < 0 || !one) bad++;
      p = k;
      if (p == 14) begin
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL dup_full_16: full=%b need 0 after 16 accepts", full); end
      end
    end
    checks++;
    if (bad !== 0 || full !== 1'b1 || dup_err !== 1'b1) begin
      failures++; $display("FAIL dup_full_17: bad=%0d full=%b dup=%b need 0/1/1", bad, full, dup_err);
    end
    build_exp();
    drain_stream(1, N * N, n, uns, to);
    checks++;
    if (to || n !== N * N) begin failures++; $display("FAIL dup_count: got %0d need 16", n); end
    for (int k = 0; k < got_v.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_v[k] !== exp_q[k]) begin
        failures++; $display("FAIL dup_elem%0d: got %0d need %0d", k, got_v[k], exp_q[k]);
      end
    end
    checks++;
    if (mdl[1][2] !== 32'd9) begin failures++; $display("FAIL dup_model: got %0d need 9", mdl[1][2]); end
    pulse_clear();
  endtask

  task automatic test_backpressure();
    int bad, early, n, uns;
    bit to;
    fill_seq(0, 32'h1000, bad, early);
    build_exp();
    drain_stream(3, N * N, n, uns, to);
    checks++;
    if (bad !== 0 || to || n !== N * N || uns !== 0) begin
      failures++;
      $display("FAIL bp_stream: bad=%0d to=%b n=%0d unstable=%0d need 0/0/16/0", bad, to, n, uns);
    end
    for (int k = 0; k < got_v.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_v[k] !== exp_q[k] || got_i[k] !== IW'(k / N) || got_j[k] !== IW'(k % N)) begin
        failures++; $display("FAIL bp_elem%0d: got %0h need %0h", k, got_v[k], exp_q[k]);
      end
    end
    checks++;
    if (done !== 1'b1 || out_stb !== 1'b0) begin
      failures++; $display("FAIL bp_done: done=%b stb=%b need 1/0", done, out_stb);
    end
    pulse_clear();
  endtask

  task automatic test_clear_drain();
    int bad, early, n, uns;
    bit to;
    fill_seq(1, 500, bad, early);
    build_exp();
    drain_stream(1, 5, n, uns, to);
    checks++;
    if (n !== 5 || got_v.size() < 5 || got_v[4] !== exp_q[4] || out_stb !== 1'b1) begin
      failures++; $display("FAIL clr_partial: n=%0d stb=%b need 5/1", n, out_stb);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (out_stb !== 1'b0 || full !== 1'b0 || done !== 1'b0 || dbg_state !== 2'(ST_COLLECT)) begin
      failures++;
      $display("FAIL clr_state: stb=%b full=%b done=%b st=%0d need 0/0/0/0", out_stb, full, done, dbg_state);
    end
    // clear together with z_stb: no accept and no ack
    z_i = 2'd3; z_j = 2'd3; z_in = 32'hbad; z_stb = 1'b1; clear = 1'b1;
    @(negedge clk);
    z_stb = 1'b0; clear = 1'b0;
    checks++;
    if (z_ack !== 1'b0) begin failures++; $display("FAIL clr_with_stb: ack=%b need 0", z_ack); end
    fill_seq(0, 700, bad, early);
    checks++;
    if (bad !== 0 || early !== 0 || full !== 1'b1) begin
      failures++; $display("FAIL clr_refill: bad=%0d early=%0d full=%b need 0/0/1", bad, early, full);
    end
    build_exp();
    drain_stream(1, N * N, n, uns, to);
    checks++;
    if (to || n !== N * N || got_v.size() != N * N || got_v[15] !== exp_q[15] || got_v[1] !== exp_q[1]) begin
      failures++; $display("FAIL clr_redrain: n=%0d need 16 correct elements", n);
    end
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    int w, bad, early, n, uns;
    bit one, to;
    for (int k = 0; k < 7; k++) send_elem(IW'(k / N), IW'(k % N), W'(900 + k), w, one);
    @(negedge clk);
    z_i = 2'd1; z_j = 2'd3; z_in = 32'd907; z_stb = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (z_ack !== 1'b1) begin failures++; $display("FAIL rstmid_ack_before: ack=%b need 1", z_ack); end
    rst = 1'b0;
    #1;
    checks++;
    if (z_ack !== 1'b0 || full !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_async: ack=%b full=%b done=%b need 0/0/0", z_ack, full, done);
    end
    z_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // bitmap and count must have been wiped: 15 new elements are not enough
    bad = 0;
    for (int k = 0; k < N * N - 1; k++) begin
      send_elem(IW'(k / N), IW'(k % N), W'(1200 + k), w, one);
      if (w < 0 || !one) bad++;
    end
    checks++;
    if (full !== 1'b0 || bad !== 0) begin failures++; $display("FAIL rstmid_refill15: full=%b bad=%0d need 0/0", full, bad); end
    send_elem(2'd3, 2'd3, 32'd1215, w, one);
    checks++;
    if (full !== 1'b1 || out_stb !== 1'b1) begin
      failures++; $display("FAIL rstmid_refill16: full=%b stb=%b need 1/1", full, out_stb);
    end
    drain_stream(1, 3, n, uns, to);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_stb !== 1'b0 || full !== 1'b0 || out_value !== '0 || dbg_state !== 2'(ST_COLLECT)) begin
      failures++; $display("FAIL rstmid_drain: stb=%b full=%b val=%0d st=%0d need 0/0/0/0", out_stb, full, out_value, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    early = 0;
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) mdl[a][b] = '0;
    test_reset();
    test_in_order_fill();
    test_reverse_fill();
    test_duplicate();
    test_backpressure();
    test_clear_drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
